// File: rtl/i2c_reg_slave.sv
// ============================================================================
// Module   : i2c_reg_slave
// Brief    : I2C target that turns [DEV, SUB, DATA...] writes into register
//            write strobes; optional read-back when I2C_SLV_READ_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1A,
  parameter logic       AUTO_INC   = 1'b1
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iSCL,
  input  logic       iSDA,
  output logic       oSDA_OE,
  output logic       oWR_EN,
  output logic [7:0] oWR_ADDR,
  output logic [7:0] oWR_DATA,
  output logic [7:0] oRD_ADDR,
  input  logic [7:0] iRD_DATA,
  output logic       oBUSY
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ADDR     = 4'd1;
  localparam logic [3:0] S_ADDR_ACK = 4'd2;
  localparam logic [3:0] S_SUB      = 4'd3;
  localparam logic [3:0] S_SUB_ACK  = 4'd4;
  localparam logic [3:0] S_DATA     = 4'd5;
  localparam logic [3:0] S_DATA_ACK = 4'd6;
  localparam logic [3:0] S_IGNORE   = 4'd7;
`ifdef I2C_SLV_READ_EN
  localparam logic [3:0] S_RD_SHIFT = 4'd8;
  localparam logic [3:0] S_RD_ACK   = 4'd9;
`endif

  logic       r_scl_s1, r_scl_s2, r_scl_d;
  logic       r_sda_s1, r_sda_s2, r_sda_d;
  logic [3:0] r_state;
  logic [3:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic [7:0] r_ptr;
  logic       r_sda_oe;
  logic       r_wr_en;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_busy;
`ifdef I2C_SLV_READ_EN
  logic       r_rd_req;
  logic [6:0] r_tx;
`else
  logic       w_unused_rd;
  assign w_unused_rd = ^iRD_DATA;
`endif

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_last_bit, w_match;
  logic [7:0] w_byte;

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  // Bus conditions need SCL stable high across the SDA edge.
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte     = {r_shift, r_sda_s2};
  assign w_last_bit = (r_bit_cnt == 4'd7);
  assign w_match    = (w_byte[7:1] == SLAVE_ADDR);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_scl_s1  <= 1'b1;
      r_scl_s2  <= 1'b1;
      r_scl_d   <= 1'b1;
      r_sda_s1  <= 1'b1;
      r_sda_s2  <= 1'b1;
      r_sda_d   <= 1'b1;
      r_state   <= S_IDLE;
      r_bit_cnt <= 4'd0;
      r_shift   <= 7'd0;
      r_ptr     <= 8'd0;
      r_sda_oe  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 8'd0;
      r_wr_data <= 8'd0;
      r_busy    <= 1'b0;
`ifdef I2C_SLV_READ_EN
      r_rd_req  <= 1'b0;
      r_tx      <= 7'd0;
`endif
    end else begin
      r_scl_s1 <= iSCL;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= iSDA;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
      r_wr_en  <= 1'b0;
      if (r_wr_en && AUTO_INC) r_ptr <= r_ptr + 8'd1;

      if (w_stop) begin
        r_state   <= S_IDLE;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
        r_bit_cnt <= 4'd0;
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b1;
        r_bit_cnt <= 4'd0;
      end else begin
        case (r_state)
          S_ADDR, S_SUB, S_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= w_last_bit ? 4'd0 : r_bit_cnt + 4'd1;
              if (w_last_bit) begin
                if (r_state == S_SUB) begin
                  r_ptr   <= w_byte;
                  r_state <= S_SUB_ACK;
                end else if (r_state == S_DATA) begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_ptr;
                  r_wr_data <= w_byte;
                  r_state   <= S_DATA_ACK;
                end else begin
`ifdef I2C_SLV_READ_EN
                  r_rd_req <= w_byte[0];
                  r_state  <= w_match ? S_ADDR_ACK : S_IGNORE;
`else
                  r_state  <= (w_match && !w_byte[0]) ? S_ADDR_ACK : S_IGNORE;
`endif
                end
              end
            end
          end
          // ACK phase: first fall pulls SDA low, second fall (end of 9th clock) releases.
          S_ADDR_ACK, S_SUB_ACK, S_DATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
              end else begin
                r_sda_oe <= 1'b0;
                if (r_state != S_ADDR_ACK) begin
                  r_state <= S_DATA;
`ifdef I2C_SLV_READ_EN
                end else if (r_rd_req) begin
                  r_tx      <= iRD_DATA[6:0];
                  r_sda_oe  <= ~iRD_DATA[7];
                  r_bit_cnt <= 4'd1;
                  r_state   <= S_RD_SHIFT;
`endif
                end else begin
                  r_state <= S_SUB;
                end
              end
            end
          end
`ifdef I2C_SLV_READ_EN
          S_RD_SHIFT: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd0) begin
                r_tx      <= iRD_DATA[6:0];
                r_sda_oe  <= ~iRD_DATA[7];
                r_bit_cnt <= 4'd1;
              end else if (r_bit_cnt == 4'd8) begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
                r_state   <= S_RD_ACK;
              end else begin
                r_sda_oe  <= ~r_tx[6];
                r_tx      <= {r_tx[5:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (w_scl_rise) begin
              if (!r_sda_s2) begin
                if (AUTO_INC) r_ptr <= r_ptr + 8'd1;
                r_bit_cnt <= 4'd0;
                r_state   <= S_RD_SHIFT;
              end else begin
                r_state <= S_IGNORE;
              end
            end
          end
`endif
          S_IDLE, S_IGNORE: r_state <= r_state;
          default:          r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign oSDA_OE  = r_sda_oe;
  assign oWR_EN   = r_wr_en;
  assign oWR_ADDR = r_wr_addr;
  assign oWR_DATA = r_wr_data;
  assign oRD_ADDR = r_ptr;
  assign oBUSY    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_i2c_reg_slave.sv
// ============================================================================
// Module   : tb_i2c_reg_slave
// Brief    : Directed + randomized bench for i2c_reg_slave with a transaction-
//            level model of ACKs, writes and the pointer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_i2c_reg_slave;

  localparam int         Q   = 125;     // quarter SCL period in ns; SCL = iCLK/50
  localparam logic [6:0] SLV = 7'h1A;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       oe0, oe1, wr0, wr1, busy0, busy1;
  logic [7:0] wa0, wd0, ra0, rd0, wa1, wd1, ra1, rd1;
  logic [7:0] rd_mem [256];

  int n_checks = 0;
  int n_errors = 0;

  // Only the auto-increment instance drives the shared line.
  assign sda_line = sda_m & ~oe0;
  assign rd0 = rd_mem[ra0];
  assign rd1 = rd_mem[ra1];

  always #5 clk = ~clk;

  i2c_reg_slave #(.SLAVE_ADDR(SLV), .AUTO_INC(1'b1)) u_dut (
    .iCLK(clk), .iRST(rst), .iSCL(scl_m), .iSDA(sda_line),
    .oSDA_OE(oe0), .oWR_EN(wr0), .oWR_ADDR(wa0), .oWR_DATA(wd0),
    .oRD_ADDR(ra0), .iRD_DATA(rd0), .oBUSY(busy0));

  i2c_reg_slave #(.SLAVE_ADDR(SLV), .AUTO_INC(1'b0)) u_dut_noinc (
    .iCLK(clk), .iRST(rst), .iSCL(scl_m), .iSDA(sda_line),
    .oSDA_OE(oe1), .oWR_EN(wr1), .oWR_ADDR(wa1), .oWR_DATA(wd1),
    .oRD_ADDR(ra1), .iRD_DATA(rd1), .oBUSY(busy1));

  // Write-strobe logs and SDA-drive cycle count, written only here.
  logic [15:0] log0 [256];
  logic [15:0] log1 [256];
  int n0 = 0, n1 = 0, oe_cyc = 0;
  always @(negedge clk) begin
    if (wr0) begin log0[n0[7:0]] = {wa0, wd0}; n0 = n0 + 1; end
    if (wr1) begin log1[n1[7:0]] = {wa1, wd1}; n1 = n1 + 1; end
    if (oe0) oe_cyc = oe_cyc + 1;
  end

  // Reference model state
  logic [7:0]  m_ptr0 = 8'h00, m_ptr1 = 8'h00;
  logic [15:0] exp0[$], exp1[$];
  int          rd_idx0 = 0, rd_idx1 = 0;
  logic [7:0]  txb [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tx_bit(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic rx_bit(output logic b);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_line; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) tx_bit(b[i]);
    rx_bit(a);
    ack = ~a;
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic v;
    for (int i = 7; i >= 0; i--) begin rx_bit(v); b[i] = v; end
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr0"}, n0 - rd_idx0, exp0.size());
    chk({tag, "_nwr1"}, n1 - rd_idx1, exp1.size());
    while (exp0.size() > 0) begin
      if (rd_idx0 < n0) begin chk({tag, "_wr0"}, log0[rd_idx0[7:0]], exp0.pop_front()); rd_idx0++; end
      else void'(exp0.pop_front());
    end
    while (exp1.size() > 0) begin
      if (rd_idx1 < n1) begin chk({tag, "_wr1"}, log1[rd_idx1[7:0]], exp1.pop_front()); rd_idx1++; end
      else void'(exp1.pop_front());
    end
    rd_idx0 = n0;
    rd_idx1 = n1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_oe"},   oe0,   1'b0);
    chk({tag, "_wren"}, wr0,   1'b0);
    chk({tag, "_wadr"}, wa0,   8'h00);
    chk({tag, "_wdat"}, wd0,   8'h00);
    chk({tag, "_ptr"},  ra0,   8'h00);
    chk({tag, "_busy"}, busy0, 1'b0);
  endtask

  // Full write-form transaction: START, nb bytes from txb, STOP.
  task automatic run_xfer(input int nb, input string tag);
    logic [7:0] got, expa;
    logic       a, ok;
    int         oe_snap;
    got = '0; expa = '0; oe_snap = oe_cyc;
    bus_start();
    for (int k = 0; k < nb; k++) begin send_byte(txb[k], a); got[k] = a; end
    chk({tag, "_busy_on"}, busy0, 1'b1);
    bus_stop();
    ok = (txb[0][7:1] == SLV) && !txb[0][0];
    if (ok) begin
      for (int k = 0; k < nb; k++) expa[k] = 1'b1;
      if (nb > 1) begin m_ptr0 = txb[1]; m_ptr1 = txb[1]; end
      for (int k = 2; k < nb; k++) begin
        exp0.push_back({m_ptr0, txb[k]});
        exp1.push_back({m_ptr1, txb[k]});
        m_ptr0 = m_ptr0 + 8'd1;
      end
    end
    chk({tag, "_acks"}, got, expa);
    chk({tag, "_busy_off"}, busy0, 1'b0);
    check_writes(tag);
    chk({tag, "_ptr0"}, ra0, m_ptr0);
    chk({tag, "_ptr1"}, ra1, m_ptr1);
    if (!ok) chk({tag, "_no_drive"}, oe_cyc - oe_snap, 0);
  endtask

  initial begin
    logic       a;
    logic [7:0] rb;
    int         nb;
    for (int i = 0; i < 256; i++) rd_mem[i] = 8'($urandom);
    rd_mem[8'h10] = 8'hA5;
    rd_mem[8'h11] = 8'h3C;

    repeat (5) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    txb[0] = 8'h34; txb[1] = 8'h1A; txb[2] = 8'h47;
    run_xfer(3, "wr_single");

    txb[0] = 8'h40; txb[1] = 8'h1A; txb[2] = 8'h47;
    run_xfer(3, "wr_nomatch");

    txb[0] = 8'h34; txb[1] = 8'hFE; txb[2] = 8'h11; txb[3] = 8'h22; txb[4] = 8'h33;
    run_xfer(5, "burst_wrap");

    // Repeated START keeps the pointer; STOP mid-byte discards the partial byte.
    bus_start();
    send_byte(8'h34, a); chk("rs_ack0", a, 1'b1);
    send_byte(8'h20, a); chk("rs_ack1", a, 1'b1);
    m_ptr0 = 8'h20; m_ptr1 = 8'h20;
    bus_start();
    send_byte(8'h34, a); chk("rs_ack2", a, 1'b1);
    chk("rs_ptr_kept", ra0, m_ptr0);
    chk("rs_busy", busy0, 1'b1);
    send_byte(8'h55, a); chk("rs_ack3", a, 1'b1);
    m_ptr0 = 8'h55; m_ptr1 = 8'h55;
    chk("rs_ptr_new", ra0, m_ptr0);
    tx_bit(1'b1); tx_bit(1'b0); tx_bit(1'b1); tx_bit(1'b1);
    bus_stop();
    check_writes("rs_partial");
    chk("rs_ptr_end", ra0, m_ptr0);
    chk("rs_busy_off", busy0, 1'b0);

    // Reset while the address ACK is being driven.
    bus_start();
    for (int i = 7; i >= 0; i--) tx_bit(txb[0][i]);
    chk("rstack_oe_on", oe0, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_reset("rstack");
    rst = 1'b0;
    m_ptr0 = 8'h00; m_ptr1 = 8'h00;
    bus_stop();
    check_writes("rstack_nowr");
    txb[0] = 8'h34; txb[1] = 8'h5A; txb[2] = 8'hC3;
    run_xfer(3, "post_rst");

`ifdef I2C_SLV_READ_EN
    bus_start();
    send_byte(8'h34, a); chk("rd_ack_w", a, 1'b1);
    send_byte(8'h10, a); chk("rd_ack_sub", a, 1'b1);
    m_ptr0 = 8'h10; m_ptr1 = 8'h10;
    bus_start();
    send_byte(8'h35, a); chk("rd_ack_r", a, 1'b1);
    read_byte(rb); chk("rd_byte0", rb, 8'hA5);
    tx_bit(1'b0);
    m_ptr0 = m_ptr0 + 8'd1;
    chk("rd_ptr_inc", ra0, m_ptr0);
    read_byte(rb); chk("rd_byte1", rb, 8'h3C);
    tx_bit(1'b1);
    bus_stop();
    chk("rd_ptr_end", ra0, m_ptr0);
    chk("rd_ptr_noinc", ra1, m_ptr1);
    chk("rd_busy_off", busy0, 1'b0);
    check_writes("rd_nowr");
`else
    txb[0] = 8'h35; txb[1] = 8'h10; txb[2] = 8'hAB;
    run_xfer(3, "rd_nack");
`endif

    for (int t = 0; t < 12; t++) begin
      nb = int'($urandom_range(1, 4));
      txb[0] = ($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom);
      if (txb[0][7:1] == SLV) txb[0] = 8'h34;
      for (int k = 1; k < 8; k++) txb[k] = 8'($urandom);
      run_xfer(nb, $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
